// File: rtl/rom_arb_pkg.sv
// rtl/rom_arb_pkg.sv - shared types and default widths for the ROM ddram arbiter
package rom_arb_pkg;

  localparam int STARVE_MAX_DEF = 4;
  localparam int RD_AW_DEF      = 20;
  localparam int WR_AW_DEF      = 25;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WR_WAIT,
    ST_RD_WAIT
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_LD,
    OWN_RD0,
    OWN_RD1
  } arb_owner_t;

endpackage

// File: rtl/rom_line_cache.sv
// rtl/rom_line_cache.sv - single-line read cache: tag/data/valid with lookup, fill and invalidate
// Lookup is combinational so a hit can be answered on the grant edge.
module rom_line_cache #(
  parameter int RD_AW = 20
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [RD_AW-1:0] i_lookup_addr,
  output logic             o_hit,
  output logic [63:0]      o_hit_data,
  input  logic             i_fill,
  input  logic [RD_AW-1:0] i_fill_addr,
  input  logic [63:0]      i_fill_data,
  input  logic             i_inval
);

  logic             r_valid;
  logic [RD_AW-1:0] r_tag;
  logic [63:0]      r_data;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_data  <= '0;
    end else if (i_inval) begin
      r_valid <= 1'b0;
    end else if (i_fill) begin
      r_valid <= 1'b1;
      r_tag   <= i_fill_addr;
      r_data  <= i_fill_data;
    end
  end

  assign o_hit      = r_valid && (r_tag == i_lookup_addr);
  assign o_hit_data = r_data;

endmodule

// File: rtl/rom_ddram_arbiter.sv
// rtl/rom_ddram_arbiter.sv - serialises ROM loader writes and two read clients onto one toggle-handshake ddram port
// Define ROM_CACHE_EN to add a one-line read cache in front of the ddram read channel.
module rom_ddram_arbiter
  import rom_arb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int RD_AW      = RD_AW_DEF,
  parameter int WR_AW      = WR_AW_DEF
) (
  input  logic             i_clk_sys,
  input  logic             i_reset_n,
  input  logic [WR_AW-1:0] i_ld_addr,
  input  logic [15:0]      i_ld_data,
  input  logic             i_ld_req,
  output logic             o_ld_ack,
  input  logic [RD_AW-1:0] i_rd0_addr,
  input  logic             i_rd0_req,
  output logic             o_rd0_ack,
  output logic [63:0]      o_rd0_data,
  input  logic [RD_AW-1:0] i_rd1_addr,
  input  logic             i_rd1_req,
  output logic             o_rd1_ack,
  output logic [63:0]      o_rd1_data,
  output logic [WR_AW-1:0] o_dn_wraddr,
  output logic [15:0]      o_dn_din,
  output logic             o_dn_we_req,
  input  logic             i_dn_we_ack,
  output logic [RD_AW-1:0] o_dn_rdaddr,
  output logic             o_dn_rd_req,
  input  logic             i_dn_rd_ack,
  input  logic [63:0]      i_dn_dout
);

  localparam int            SW         = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  arb_state_t       r_state;
  arb_state_t       w_state_nx;
  arb_owner_t       r_owner;
  logic [SW-1:0]    r_starve;
  logic             r_ld_ack, r_rd0_ack, r_rd1_ack;
  logic [63:0]      r_rd0_data, r_rd1_data;
  logic [WR_AW-1:0] r_dn_wraddr;
  logic [15:0]      r_dn_din;
  logic             r_dn_we_req, r_dn_rd_req;
  logic [RD_AW-1:0] r_dn_rdaddr;

  logic             w_ld_pend, w_rd0_pend, w_rd1_pend;
  logic             w_we_done, w_rd_done;
  logic             w_grant;
  arb_owner_t       w_gown;
  logic [RD_AW-1:0] w_gaddr;
  logic             w_hit;
  logic [63:0]      w_hit_data;
  logic             w_idle_grant;
  logic             w_dlv_en;
  arb_owner_t       w_dlv_own;
  logic [63:0]      w_dlv_data;

  assign w_ld_pend  = i_ld_req  != r_ld_ack;
  assign w_rd0_pend = i_rd0_req != r_rd0_ack;
  assign w_rd1_pend = i_rd1_req != r_rd1_ack;
  assign w_we_done  = i_dn_we_ack == r_dn_we_req;
  assign w_rd_done  = i_dn_rd_ack == r_dn_rd_req;

  always_comb begin
    w_grant = 1'b0;
    w_gown  = OWN_LD;
    if (w_ld_pend) begin
      w_grant = 1'b1;
      w_gown  = OWN_LD;
    end else if (w_rd1_pend && (r_starve == STARVE_LIM)) begin
      w_grant = 1'b1;
      w_gown  = OWN_RD1;
    end else if (w_rd0_pend) begin
      w_grant = 1'b1;
      w_gown  = OWN_RD0;
    end else if (w_rd1_pend) begin
      w_grant = 1'b1;
      w_gown  = OWN_RD1;
    end
  end

  assign w_gaddr      = (w_gown == OWN_RD1) ? i_rd1_addr : i_rd0_addr;
  assign w_idle_grant = (r_state == ST_IDLE) && w_grant;

`ifdef ROM_CACHE_EN
  rom_line_cache #(
    .RD_AW(RD_AW)
  ) u_cache (
    .i_clk         (i_clk_sys),
    .i_rst_n       (i_reset_n),
    .i_lookup_addr (w_gaddr),
    .o_hit         (w_hit),
    .o_hit_data    (w_hit_data),
    .i_fill        ((r_state == ST_RD_WAIT) && w_rd_done),
    .i_fill_addr   (r_dn_rdaddr),
    .i_fill_data   (i_dn_dout),
    .i_inval       (w_idle_grant && (w_gown == OWN_LD))
  );
`else
  assign w_hit      = 1'b0;
  assign w_hit_data = '0;
`endif

  // Read data reaches a client either from a cache hit on the grant edge or from a completed DDR read.
  assign w_dlv_en   = (w_idle_grant && (w_gown != OWN_LD) && w_hit) ||
                      ((r_state == ST_RD_WAIT) && w_rd_done);
  assign w_dlv_own  = (r_state == ST_IDLE) ? w_gown : r_owner;
  assign w_dlv_data = (r_state == ST_IDLE) ? w_hit_data : i_dn_dout;

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_grant) begin
          if (w_gown == OWN_LD) w_state_nx = ST_WR_WAIT;
          else if (!w_hit)      w_state_nx = ST_RD_WAIT;
        end
      end
      ST_WR_WAIT: if (w_we_done) w_state_nx = ST_IDLE;
      ST_RD_WAIT: if (w_rd_done) w_state_nx = ST_IDLE;
      default:    w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk_sys or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= ST_IDLE;
    else            r_state <= w_state_nx;
  end

  always_ff @(posedge i_clk_sys or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_owner     <= OWN_LD;
      r_ld_ack    <= 1'b0;
      r_rd0_ack   <= 1'b0;
      r_rd1_ack   <= 1'b0;
      r_rd0_data  <= '0;
      r_rd1_data  <= '0;
      r_dn_wraddr <= '0;
      r_dn_din    <= '0;
      r_dn_we_req <= 1'b0;
      r_dn_rdaddr <= '0;
      r_dn_rd_req <= 1'b0;
    end else begin
      if (w_idle_grant) begin
        r_owner <= w_gown;
        if (w_gown == OWN_LD) begin
          r_dn_wraddr <= i_ld_addr;
          r_dn_din    <= i_ld_data;
          r_dn_we_req <= ~r_dn_we_req;
        end else if (!w_hit) begin
          r_dn_rdaddr <= w_gaddr;
          r_dn_rd_req <= ~r_dn_rd_req;
        end
      end
      if ((r_state == ST_WR_WAIT) && w_we_done) r_ld_ack <= ~r_ld_ack;
      if (w_dlv_en) begin
        if (w_dlv_own == OWN_RD1) begin
          r_rd1_data <= w_dlv_data;
          r_rd1_ack  <= ~r_rd1_ack;
        end else begin
          r_rd0_data <= w_dlv_data;
          r_rd0_ack  <= ~r_rd0_ack;
        end
      end
    end
  end

  // Counts port-0 wins over a waiting port 1; any port-1 grant or port 1 going idle resets it.
  always_ff @(posedge i_clk_sys or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_starve <= '0;
    end else if (!w_rd1_pend) begin
      r_starve <= '0;
    end else if (w_idle_grant) begin
      if (w_gown == OWN_RD1)
        r_starve <= '0;
      else if ((w_gown == OWN_RD0) && (r_starve != STARVE_LIM))
        r_starve <= r_starve + SW'(1);
    end
  end

  assign o_ld_ack    = r_ld_ack;
  assign o_rd0_ack   = r_rd0_ack;
  assign o_rd1_ack   = r_rd1_ack;
  assign o_rd0_data  = r_rd0_data;
  assign o_rd1_data  = r_rd1_data;
  assign o_dn_wraddr = r_dn_wraddr;
  assign o_dn_din    = r_dn_din;
  assign o_dn_we_req = r_dn_we_req;
  assign o_dn_rdaddr = r_dn_rdaddr;
  assign o_dn_rd_req = r_dn_rd_req;

endmodule

// File: tb/tb_rom_ddram_arbiter.sv
// tb/tb_rom_ddram_arbiter.sv - scoreboard bench for rom_ddram_arbiter with a toggle-handshake ddram model
module tb_rom_ddram_arbiter;

  localparam int RD_AW  = 20;
  localparam int WR_AW  = 25;
  localparam int WR_LAT = 5;
  localparam int RD_LAT = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WR_AW-1:0] ld_addr = '0;
  logic [15:0]      ld_data = '0;
  logic             ld_req = 1'b0;
  logic             ld_ack;
  logic [RD_AW-1:0] rd0_addr = '0;
  logic             rd0_req = 1'b0;
  logic             rd0_ack;
  logic [63:0]      rd0_data;
  logic [RD_AW-1:0] rd1_addr = '0;
  logic             rd1_req = 1'b0;
  logic             rd1_ack;
  logic [63:0]      rd1_data;
  logic [WR_AW-1:0] dn_wraddr;
  logic [15:0]      dn_din;
  logic             dn_we_req;
  logic             dn_we_ack = 1'b0;
  logic [RD_AW-1:0] dn_rdaddr;
  logic             dn_rd_req;
  logic             dn_rd_ack = 1'b0;
  logic [63:0]      dn_dout = '0;

  rom_ddram_arbiter #(
    .STARVE_MAX(4), .RD_AW(RD_AW), .WR_AW(WR_AW)
  ) dut (
    .i_clk_sys(clk), .i_reset_n(rst_n),
    .i_ld_addr(ld_addr), .i_ld_data(ld_data), .i_ld_req(ld_req), .o_ld_ack(ld_ack),
    .i_rd0_addr(rd0_addr), .i_rd0_req(rd0_req), .o_rd0_ack(rd0_ack), .o_rd0_data(rd0_data),
    .i_rd1_addr(rd1_addr), .i_rd1_req(rd1_req), .o_rd1_ack(rd1_ack), .o_rd1_data(rd1_data),
    .o_dn_wraddr(dn_wraddr), .o_dn_din(dn_din), .o_dn_we_req(dn_we_req), .i_dn_we_ack(dn_we_ack),
    .o_dn_rdaddr(dn_rdaddr), .o_dn_rd_req(dn_rd_req), .i_dn_rd_ack(dn_rd_ack), .i_dn_dout(dn_dout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [15:0] din;
  } op_t;

  op_t         exp_op[$];
  logic [63:0] exp_rd0[$];
  logic [63:0] exp_rd1[$];

  int n_tests = 0;
  int n_fail  = 0;
  int n_ld = 0, n_ack0 = 0, n_ack1 = 0, n_wr = 0, n_rd = 0;
  int ack0_cyc = 0, dnrd_cyc = 0, req0_cyc = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mem_data(input logic [RD_AW-1:0] a);
    logic [63:0] m;
    m = {44'h0, a ^ 20'h10};
    return 64'h0123_4567_89AB_CDEF ^ (m * 64'h0001_0001_0001_0001);
  endfunction

  // ddram model plus client-side monitors, all sampled on the falling edge
  initial begin
    logic p_ld, p_rd0, p_rd1;
    int we_cnt, rd_cnt;
    logic [RD_AW-1:0] rd_a;
    op_t op;
    p_ld = 0; p_rd0 = 0; p_rd1 = 0; we_cnt = 0; rd_cnt = 0; rd_a = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        p_ld = 0; p_rd0 = 0; p_rd1 = 0; we_cnt = 0; rd_cnt = 0;
        dn_we_ack = 0; dn_rd_ack = 0;
      end else begin
        if (ld_ack != p_ld) begin p_ld = ld_ack; n_ld++; end
        if (rd0_ack != p_rd0) begin
          p_rd0 = rd0_ack; n_ack0++; ack0_cyc = cyc;
          if (exp_rd0.size() == 0) check("rd0_spurious_ack", 64'(1), 64'(0));
          else check("rd0_data", rd0_data, exp_rd0.pop_front());
        end
        if (rd1_ack != p_rd1) begin
          p_rd1 = rd1_ack; n_ack1++;
          if (exp_rd1.size() == 0) check("rd1_spurious_ack", 64'(1), 64'(0));
          else check("rd1_data", rd1_data, exp_rd1.pop_front());
        end
        if (dn_we_req != dn_we_ack) begin
          if (we_cnt == 0) begin
            n_wr++;
            if (exp_op.size() == 0) check("unexpected_write", 64'(1), 64'(0));
            else begin
              op = exp_op.pop_front();
              check("op_kind_wr", 64'(2), 64'(op.kind));
              check("dn_wraddr", 64'(dn_wraddr), 64'(op.addr[WR_AW-1:0]));
              check("dn_din", 64'(dn_din), 64'(op.din));
            end
          end
          we_cnt++;
          if (we_cnt == WR_LAT) begin dn_we_ack = dn_we_req; we_cnt = 0; end
        end
        if (dn_rd_req != dn_rd_ack) begin
          if (rd_cnt == 0) begin
            n_rd++;
            rd_a = dn_rdaddr;
            if (exp_op.size() == 0) check("unexpected_read", 64'(1), 64'(0));
            else begin
              op = exp_op.pop_front();
              check("op_kind_rd", 64'(0), 64'((op.kind == 2) ? 2 : 0));
              check("dn_rdaddr", 64'(dn_rdaddr), 64'(op.addr[RD_AW-1:0]));
            end
          end
          rd_cnt++;
          if (rd_cnt == RD_LAT) begin
            dn_dout = mem_data(rd_a); dn_rd_ack = dn_rd_req; rd_cnt = 0; dnrd_cyc = cyc;
          end
        end
      end
    end
  end

  task automatic ld_write(input logic [WR_AW-1:0] a, input logic [15:0] d);
    @(negedge clk);
    ld_addr = a; ld_data = d;
    exp_op.push_back('{2, 32'(a), d});
    ld_req = ~ld_req;
  endtask

  task automatic rd0_issue(input logic [RD_AW-1:0] a, input bit to_ddr);
    rd0_addr = a;
    exp_rd0.push_back(mem_data(a));
    if (to_ddr) exp_op.push_back('{0, 32'(a), 16'h0});
    req0_cyc = cyc;
    rd0_req = ~rd0_req;
  endtask

  task automatic rd1_issue(input logic [RD_AW-1:0] a);
    rd1_addr = a;
    exp_rd1.push_back(mem_data(a));
    rd1_req = ~rd1_req;
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (k < 400 && !(ld_req == ld_ack && rd0_req == rd0_ack && rd1_req == rd1_ack &&
                        dn_we_req == dn_we_ack && dn_rd_req == dn_rd_ack)) begin
      @(negedge clk); k++;
    end
    if (k >= 400) check(tag, 64'(0), 64'(1));
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_ld, b_rd, b_ack1, i0, i1, k;
    logic b_rdreq;
    int order[10];
    order = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

    repeat (3) @(negedge clk);
    check("rst_ld_ack", 64'(ld_ack), 64'(0));
    check("rst_rd0_ack", 64'(rd0_ack), 64'(0));
    check("rst_dn_we_req", 64'(dn_we_req), 64'(0));
    check("rst_dn_rd_req", 64'(dn_rd_req), 64'(0));
    check("rst_rd0_data", rd0_data, 64'(0));
    check("rst_dn_wraddr", 64'(dn_wraddr), 64'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // loader burst
    b_ld = n_ld; b_rd = n_rd; b_rdreq = dn_rd_req;
    for (int i = 0; i < 3; i++) begin
      ld_write(WR_AW'(2 * i), 16'hA500 + 16'(i));
      wait_idle("t1_timeout");
    end
    check("t1_ld_acks", 64'(n_ld - b_ld), 64'(3));
    check("t1_no_reads", 64'(n_rd - b_rd), 64'(0));
    check("t1_dn_rd_req", 64'(dn_rd_req), 64'(b_rdreq));

    // single port-0 miss
    b_ack1 = n_ack1;
    @(negedge clk);
    rd0_issue(20'h00010, 1'b1);
    wait_idle("t2_timeout");
    check("t2_data_const", rd0_data, 64'h0123_4567_89AB_CDEF);
    check("t2_ack_latency", 64'(ack0_cyc - dnrd_cyc), 64'(1));
    check("t2_rd1_untouched", 64'(n_ack1 - b_ack1), 64'(0));

    // starvation: both ports kept pending
    i0 = 0; i1 = 0;
    for (int g = 0; g < 10; g++) begin
      if (order[g] == 0) begin exp_op.push_back('{0, 32'h100 + 32'(i0), 16'h0}); i0++; end
      else begin exp_op.push_back('{1, 32'h200 + 32'(i1), 16'h0}); i1++; end
    end
    @(negedge clk);
    rd0_addr = 20'h100; exp_rd0.push_back(mem_data(20'h100)); rd0_req = ~rd0_req;
    rd1_issue(20'h200);
    i0 = 1; i1 = 1; k = 0;
    while (k < 600 && !(i0 == 8 && i1 == 2 && rd0_req == rd0_ack && rd1_req == rd1_ack)) begin
      @(negedge clk); k++;
      if (rd0_ack == rd0_req && i0 < 8) begin
        rd0_addr = 20'h100 + 20'(i0); exp_rd0.push_back(mem_data(rd0_addr)); rd0_req = ~rd0_req; i0++;
      end
      if (rd1_ack == rd1_req && i1 < 2) begin rd1_issue(20'h200 + 20'(i1)); i1++; end
    end
    if (k >= 600) check("t3_timeout", 64'(0), 64'(1));
    wait_idle("t3_drain");
    check("t3_ops_consumed", 64'(exp_op.size()), 64'(0));

    // loader and port 0 in the same cycle
    @(negedge clk);
    ld_addr = 25'h100; ld_data = 16'h5A5A;
    exp_op.push_back('{2, 32'h100, 16'h5A5A});
    ld_req = ~ld_req;
    rd0_issue(20'h00011, 1'b1);
    wait_idle("t4_timeout");
    check("t4_ops_consumed", 64'(exp_op.size()), 64'(0));

    // repeated line, then loader write
    b_rd = n_rd;
    @(negedge clk); rd0_issue(20'h00020, 1'b1); wait_idle("t5_a");
`ifdef ROM_CACHE_EN
    @(negedge clk); rd0_issue(20'h00020, 1'b0); wait_idle("t5_b");
    check("t5_hit_latency", 64'(ack0_cyc - req0_cyc), 64'(1));
    check("t5_one_ddr_read", 64'(n_rd - b_rd), 64'(1));
`else
    @(negedge clk); rd0_issue(20'h00020, 1'b1); wait_idle("t5_b");
    check("t5_two_ddr_reads", 64'(n_rd - b_rd), 64'(2));
`endif
    b_rd = n_rd;
    ld_write(25'h40, 16'h1234); wait_idle("t5_c");
    @(negedge clk); rd0_issue(20'h00020, 1'b1); wait_idle("t5_d");
    check("t5_refetch_after_write", 64'(n_rd - b_rd), 64'(1));

    // reset during RD_WAIT
    b_ld = n_ack0;
    @(negedge clk); rd0_issue(20'h00030, 1'b1);
    @(negedge clk);
    check("t6_in_rd_wait", 64'(dn_rd_req != dn_rd_ack), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check("t6_ld_ack", 64'(ld_ack), 64'(0));
    check("t6_rd0_ack", 64'(rd0_ack), 64'(0));
    check("t6_rd1_ack", 64'(rd1_ack), 64'(0));
    check("t6_dn_we_req", 64'(dn_we_req), 64'(0));
    check("t6_dn_rd_req", 64'(dn_rd_req), 64'(0));
    exp_rd0.delete();
    ld_req = 0; rd0_req = 0; rd1_req = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("t6_no_ack_after", 64'(n_ack0 - b_ld), 64'(0));
    check("t6_no_reads_after", 64'(exp_op.size()), 64'(0));
    @(negedge clk); rd0_issue(20'h00040, 1'b1);
    wait_idle("t6_resume");
    check("t6_resume_ack", 64'(n_ack0 - b_ld), 64'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
